// File: rtl/sqrt_iter_unit.sv
// Iterative integer square root by odd-number accumulation.
// The loop keeps square = (k+1)^2 and delta = 2k+3. It stops at the first
// square greater than the radicand, which gives root = k = floor(sqrt(radicand)).
// N must be even and at least 4.
module sqrt_iter_unit #(
  parameter int unsigned N = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   radicand,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N/2-1:0] root
);

  localparam int unsigned SQ_W = N + 1;
  localparam int unsigned DL_W = N / 2 + 2;
  localparam int unsigned RT_W = N / 2;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [SQ_W-1:0] square;
  logic [DL_W-1:0] delta;

  // Control FSM and accumulation datapath, all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_reg  <= '0;
      square <= SQ_W'(1);
      delta  <= DL_W'(3);
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      root   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= radicand;
            square <= SQ_W'(1);
            delta  <= DL_W'(3);
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (square <= {1'b0, a_reg}) begin
            square <= square + SQ_W'(delta);
            delta  <= delta + DL_W'(2);
          end else begin
            // delta = 2k+3 here, so (delta >> 1) - 1 recovers k
            root  <= RT_W'((delta >> 1) - DL_W'(1));
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Self-checking bench for sqrt_iter_unit (N=16): directed table, random
// operands against an arithmetic reference, and multi-cycle corner sequences.
module tb_sqrt_iter_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] radicand;
  logic        ready;
  logic        busy;
  logic        done;
  logic [7:0]  root;
  bit          clk_en;

  int total;
  int passed;

  sqrt_iter_unit #(.N(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .radicand (radicand),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .root     (root)
  );

  // Gated clock so reset can be exercised with the clock stopped
  always #5 clock = clk_en ? ~clock : clock;

  typedef struct {
    int a;
    int exp_root;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: largest r with r*r <= a
  function automatic int ref_isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  // Issue one request (caller is at a negedge) and wait for done, bounded
  task automatic run_op(input int a, output int lat, output int r,
                        output bit got, output bit rdy, output bit bsy);
    start    = 1'b1;
    radicand = 16'(a);
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    got = 1'b0;
    r = 0; rdy = 1'b0; bsy = 1'b0;
    while (lat < 400 && !got) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        r   = int'(root);
        rdy = ready;
        bsy = busy;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input int a,
                               input int exp_root, input int exp_lat);
    int lat, r;
    bit got, rdy, bsy;
    run_op(a, lat, r, got, rdy, bsy);
    check({tag, " done_seen"}, longint'(got), 1);
    check({tag, " root"}, r, exp_root);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ready_at_done"}, longint'(rdy), 1);
    check({tag, " busy_at_done"}, longint'(bsy), 0);
  endtask

  initial begin
    vec_t vecs[$];
    int   lat, r, a, ndone;
    bit   got, rdy, bsy;

    total = 0; passed = 0;
    clock = 1'b0; clk_en = 1'b0;
    reset = 1'b0; start = 1'b0; radicand = '0;

    // Asynchronous reset with clock stopped
    #2 reset = 1'b1;
    #1;
    check("rst ready", longint'(ready), 1);
    check("rst busy",  longint'(busy), 0);
    check("rst done",  longint'(done), 0);
    check("rst root",  longint'(root), 0);
    #5 reset = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clock);
    check("idle square", longint'(dut.square), 1);
    check("idle delta",  longint'(dut.delta), 3);

    // Directed table
    vecs.push_back('{0, 0, 1});
    vecs.push_back('{1, 1, 2});
    vecs.push_back('{3, 1, 2});
    vecs.push_back('{4, 2, 3});
    vecs.push_back('{15, 3, 4});
    vecs.push_back('{16, 4, 5});
    vecs.push_back('{99, 9, 10});
    vecs.push_back('{1000, 31, 32});
    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", vecs[i].a), vecs[i].a,
                    vecs[i].exp_root, vecs[i].exp_lat);
      @(negedge clock);
      check($sformatf("vec%0d single_pulse", vecs[i].a), longint'(done), 0);
    end

    // Worst case, peak square must reach 65536 without wrapping
    run_and_check("max", 65535, 255, 256);
    check("max peak_square", longint'(dut.square), 65536);
    @(negedge clock);

    // Random operands against the reference
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(65535, 0));
      run_and_check($sformatf("rnd%0d", a), a, ref_isqrt(a), ref_isqrt(a) + 1);
      @(negedge clock);
    end

    // Start during CALC is ignored
    start = 1'b1; radicand = 16'd100;
    @(posedge clock);
    #1 radicand = 16'd9;
    lat = 0; ndone = 0; r = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        ndone++;
        r = int'(root);
        if (ndone == 1) lat = c;
      end
    end
    start = 1'b0;
    check("busy_start done_count", ndone, 1);
    check("busy_start root", r, 10);
    check("busy_start latency", lat, 11);

    // Back-to-back: new request accepted in the done cycle
    run_and_check("b2b first", 24, 4, 5);
    run_and_check("b2b second", 25, 5, 6);
    @(negedge clock);

    // Reset mid-operation aborts without a done pulse
    start = 1'b1; radicand = 16'd1000;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort ready", longint'(ready), 1);
    check("abort busy",  longint'(busy), 0);
    check("abort done",  longint'(done), 0);
    check("abort root",  longint'(root), 0);
    check("abort square", longint'(dut.square), 1);
    check("abort delta",  longint'(dut.delta), 3);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_and_check("after_abort", 1000, 31, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sqrt_iter_unit.md
# sqrt_iter_unit

Iterative integer square-root unit for the second-version square-root datapath. It owns the odd-number-accumulation loop, where `square` starts at 1 and `delta` starts at 3. Each iteration adds `delta` to `square` and adds 2 to `delta`, and the loop stops when `square` exceeds the radicand. On completion it produces `root = floor(sqrt(radicand))`. The 17-bit square register, with its reset value of 1, sits inside this loop, and its load/enable control comes from this block's state machine.

## Interface
- `N`, default 16: radicand width. Must be even and ≥ 4.
  - Square width is N+1.
  - Delta width is N/2+2.
  - Root width is N/2.
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Forces every register to its reset value immediately.
- `start`  in  1: request. Sampled only when `ready`=1.
- `radicand`  in  N: operand. Captured on the accepting edge and ignored at all other times.
- `ready`  out  1: high in IDLE. Reset value 1.
- `busy`  out  1: high in CALC. Reset value 0.
- `done`  out  1: one-cycle completion pulse. Reset value 0.
- `root`  out  N/2: result. Holds its value until the next completion. Reset value 0.

## Operation
- Internal registers and reset values:
  - `a_reg` (N bits) resets to 0.
  - `square` (N+1 bits) resets to 1.
  - `delta` (N/2+2 bits) resets to 3.
- State machine: IDLE → CALC → IDLE. Reset state is IDLE.
- IDLE:
  - `ready`=1, `busy`=0.
  - If `start`=1 at the edge: `a_reg`<=`radicand`, `square`<=1, `delta`<=3, next state CALC.
  - Otherwise all registers hold.
- CALC, one comparison per cycle:
  - If `square` ≤ `a_reg` (unsigned, with `a_reg` zero-extended to N+1 bits): `square`<=`square`+`delta` and `delta`<=`delta`+2. Remain in CALC.
  - Otherwise: `root`<=(`delta`>>1)−1, truncated to N/2 bits. `done`<=1 for exactly one cycle. Next state IDLE.
- Correctness: after k iterations, `square`=(k+1)² and `delta`=2k+3, so `root`=k=floor(sqrt(a)).
- Width guarantees for N=16:
  - Maximum `square` = 65536, which fits in 17 bits.
  - Maximum `delta` = 513, which fits in 10 bits.
  - No overflow is possible, so no saturation logic is required.
- `start` while busy: ignored. No queuing, and `a_reg` is not disturbed.
- `radicand` changes while busy: no effect on the result.
- `start`=1 in the same cycle `done`=1: that cycle is IDLE, so the request is accepted. Back-to-back operations therefore have zero bubble beyond the `done` cycle.
- `reset` mid-operation:
  - The computation is aborted and the state returns to IDLE.
  - `root`=0, `done`=0, `square`=1, `delta`=3.
  - No `done` pulse is emitted for the aborted operation.

## Timing
- Accepting edge e0: `start`=1 with `ready`=1. `busy` rises after e0.
- With k = floor(sqrt(radicand)), CALC lasts k+1 cycles: k iterations plus one failing compare.
- `done`=1 and the valid `root` are visible after edge e0+k+1. Latency is therefore k+1 clocks from the accepting edge.
- Example latencies: radicand 0 → 1 clock; radicand 65535 → 256 clocks (worst case for N=16).
- `ready` returns to 1 in the same cycle `done` is high. `busy` falls in that cycle.
- `root` changes only on the completion edge or on reset.

## Test plan
- Reset with `clock` stopped: `ready`=1, `busy`=0, `done`=0, `root`=0 asynchronously. After release, internal `square`=1 and `delta`=3.
- Radicand 0, start → `done` 1 clock after acceptance, `root`=0. Radicand 3 → `root`=1 after 2 clocks. Radicand 16 → `root`=4 after 5 clocks.
- Radicand 65535 → `root`=255 after 256 clocks. Peak `square` reaches 65536 with no wrap.
- Start with radicand 100, then drive `start`=1 with radicand 9 during CALC → single `done`, `root`=10. The second request is ignored.
- Radicand 24 completes (`root`=4). `start`=1 with radicand 25 held high in the `done` cycle → accepted. The next `done` arrives 6 clocks later with `root`=5.
- Start radicand 1000, assert `reset` after 10 clocks → immediate IDLE, `root`=0, no `done`. A subsequent radicand 1000 → `root`=31 after 32 clocks.
